regwrite_ctrl: RTL

REGWRITE_CTRL -- requirements
Module: regwrite_ctrl

---
 rtl/regwrite_ctrl_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 101 ++++++++++
 rtl/regwrite_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/regwrite_ctrl_pkg.sv
// Shared widths, defaults and the pending-write entry type for the write-back controller.
package regwrite_ctrl_pkg;

  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_W      = 5;

  typedef logic [REG_W-1:0] reg_addr_t;

  // One pending register-file write at the default data width.
  typedef struct packed {
    reg_addr_t             rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

  // A source register hazards only when it names a real register (x0 never stalls).
  function automatic logic src_hit(input reg_addr_t src, input logic hit);
    return (src != '0) && hit;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order pending-write queue: two ordered push ports, one pop, and
// per-entry destination compare against two decode source registers.
module wb_fifo
  import regwrite_ctrl_pkg::*;
#(
  parameter int unsigned N     = DATA_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF  // power of two, >= 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push0,
  input  logic [REG_W-1:0]             i_rd0,
  input  logic [N-1:0]                 i_data0,
  input  logic                         i_push1,
  input  logic [REG_W-1:0]             i_rd1,
  input  logic [N-1:0]                 i_data1,
  input  logic                         i_pop,
  output logic [REG_W-1:0]             o_head_rd,
  output logic [N-1:0]                 o_head_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  input  logic [REG_W-1:0]             i_cmp1,
  input  logic [REG_W-1:0]             i_cmp2,
  output logic                         o_match1,
  output logic                         o_match2
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    reg_addr_t    rd;
    logic [N-1:0] data;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic             w_pop;
  logic [1:0]       w_n_push;
  logic [PTR_W-1:0] w_wptr_next;
  logic [PTR_W-1:0] w_wptr_plus1;

  // Pop only ever takes a valid entry; push count is 0, 1 or 2.
  always_comb begin
    w_pop        = i_pop && (r_count != '0);
    w_n_push     = 2'({1'b0, i_push0}) + 2'({1'b0, i_push1});
    w_wptr_plus1 = r_wptr + PTR_W'(1);
    w_wptr_next  = r_wptr + PTR_W'(w_n_push);
  end

  // Entry storage; port 0 always lands ahead of port 1 when both push.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (i_push0) begin
        r_mem[r_wptr] <= '{rd: i_rd0, data: i_data0};
      end
      if (i_push1) begin
        r_mem[i_push0 ? w_wptr_plus1 : r_wptr] <= '{rd: i_rd1, data: i_data1};
      end
    end
  end

  // Pointers and occupancy; both pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= w_wptr_next;
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_n_push) - CNT_W'(w_pop);
    end
  end

  // Head and occupancy are read straight from state.
  always_comb begin
    o_head_rd   = r_mem[r_rptr].rd;
    o_head_data = r_mem[r_rptr].data;
    o_count     = r_count;
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    o_match1 = 1'b0;
    o_match2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] off;
      off = PTR_W'(i) - r_rptr;
      if (CNT_W'(off) < r_count) begin
        if (r_mem[i].rd == i_cmp1) o_match1 = 1'b1;
        if (r_mem[i].rd == i_cmp2) o_match2 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regwrite_ctrl.sv
// Register-file write-back controller: arbitrates load and ALU results into
// an in-order pending queue, retires one write per cycle, and flags
// read-after-write hazards for the decode stage.
module regwrite_ctrl
  import regwrite_ctrl_pkg::*;
#(
  parameter int unsigned N     = DATA_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF  // power of two, >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic [REG_W-1:0] mem_reg,
  input  logic [N-1:0]     mem_data,
  output logic             mem_ready,
  input  logic             alu_valid,
  input  logic [REG_W-1:0] alu_reg,
  input  logic [N-1:0]     alu_data,
  output logic             alu_ready,
  output logic [REG_W-1:0] writereg,
  output logic [N-1:0]     data,
  output logic             rw,
  input  logic [REG_W-1:0] readreg1,
  input  logic [REG_W-1:0] readreg2,
  output logic             stall
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] w_count;
  logic             w_mem_push;
  logic             w_alu_push;
  logic             w_pop;
  logic [REG_W-1:0] w_head_rd;
  logic [N-1:0]     w_head_data;
  logic             w_match1;
  logic             w_match2;

  logic             r_rw;
  logic [REG_W-1:0] r_writereg;
  logic [N-1:0]     r_data;

  // Admission from pre-edge occupancy; ALU leaves a slot for a concurrent load,
  // and the same-edge retire is deliberately not credited.
  always_comb begin
    mem_ready = (w_count <= CNT_W'(DEPTH - 1));
    if (mem_valid) begin
      alu_ready = (w_count <= CNT_W'(DEPTH - 2));
    end else begin
      alu_ready = (w_count <= CNT_W'(DEPTH - 1));
    end
  end

  // Results to x0 complete the handshake but are dropped instead of queued.
  always_comb begin
    w_mem_push = mem_valid && mem_ready && (mem_reg != '0);
    w_alu_push = alu_valid && alu_ready && (alu_reg != '0);
    w_pop      = (w_count != '0);
  end

  wb_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push0     (w_mem_push),
    .i_rd0       (mem_reg),
    .i_data0     (mem_data),
    .i_push1     (w_alu_push),
    .i_rd1       (alu_reg),
    .i_data1     (alu_data),
    .i_pop       (w_pop),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_count     (w_count),
    .i_cmp1      (readreg1),
    .i_cmp2      (readreg2),
    .o_match1    (w_match1),
    .o_match2    (w_match2)
  );

  // Retire register: one write pulse per popped entry, address/data hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rw       <= 1'b0;
      r_writereg <= '0;
      r_data     <= '0;
    end else if (w_pop) begin
      r_rw       <= 1'b1;
      r_writereg <= w_head_rd;
      r_data     <= w_head_data;
    end else begin
      r_rw       <= 1'b0;
    end
  end

  // Hazard covers queued entries and the write currently being retired.
  always_comb begin
    stall = src_hit(readreg1, w_match1 || (r_rw && (r_writereg == readreg1)))
         || src_hit(readreg2, w_match2 || (r_rw && (r_writereg == readreg2)));
  end

  always_comb begin
    rw       = r_rw;
    writereg = r_writereg;
    data     = r_data;
  end

endmodule
